axil_regbank: RTL and testbench
===============================

# axil_regbank

Parametrised AXI4-Lite slave register bank: the next generation of the fixed four-register `final` slave IP. Provides NUM_REGS software-visible registers of C_S_AXI_DATA_WIDTH bits each, with byte-strobe writes, a per-register read-only mask backed by fabric status inputs, and per-register write-strobe pulses to downstream logic. Sits behind the PS/interconnect AXI4-Lite master, driving control words into user fabric.

## Interface

Parameters:
- C_S_AXI_DATA_WIDTH, 32, register and bus data width (32 or 64).
- NUM_REGS, 8, number of registers (2..64).
- C_S_AXI_ADDR_WIDTH, 5, byte address width; must be ≥ clog2(NUM_REGS)+clog2(C_S_AXI_DATA_WIDTH/8).
- RO_MASK, 0, NUM_REGS-bit mask; bit i set means register i is read-only and mirrors status_in.

Ports:
- Clock and reset: one clock and one reset. The reset is asynchronous and active-low.
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake.
- S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
- S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake.
- S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake.
- reg_out  out  NUM_REGS*C_S_AXI_DATA_WIDTH  flattened register contents; register i occupies slice i.
- status_in  in  NUM_REGS*C_S_AXI_DATA_WIDTH  read-back source for RO registers (slices for RW registers unused).
- wr_pulse  out  NUM_REGS  one-cycle pulse on each committed write to RW register i.

## Operation

- Index = ADDR[C_S_AXI_ADDR_WIDTH-1 : clog2(DW/8)]. Low byte-offset bits are ignored.
- Write FSM states:
  - W_IDLE: AWREADY=WREADY=1.
  - W_ADDR: AW latched, WREADY=1, AWREADY=0.
  - W_DATA: W latched, AWREADY=1, WREADY=0.
  - W_RESP: BVALID=1, both readies 0.
- Write transitions:
  - AW and W same cycle → W_RESP.
  - Otherwise hold whichever arrived first until the other arrives, then → W_RESP.
  - W_RESP → W_IDLE on BVALID&BREADY.
- Commit occurs on the edge entering W_RESP. Bytes with WSTRB=1 update; others are retained.
- A write to an RO register or to index ≥ NUM_REGS is dropped, with no wr_pulse.
- Read FSM states:
  - R_IDLE: ARREADY=1. On ARVALID, register RDATA/RRESP → R_DATA.
  - R_DATA: RVALID=1. Holds RDATA until RREADY → R_IDLE.
- RDATA sources: RW index gives the stored register; RO index gives the status_in slice, sampled at the AR handshake edge.
- Read and write channels are independent. A read and a write commit to the same register on the same edge: the read returns the pre-write value.

## Timing

- ARESETN low (async): all registers 0; reg_out=0; wr_pulse=0; BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0; AWREADY=WREADY=ARREADY=0.
- Readies assert on the second rising edge after ARESETN deasserts, via a registered ready-enable flag.
- Reset asserted mid-transaction: pending AW/W/B/R state is discarded immediately, and both FSMs return to IDLE.
- Write latency: handshake edge N → BVALID and reg_out updated after edge N+1. wr_pulse is high for exactly the cycle following the commit edge.
- Read latency: AR handshake edge N → RVALID after edge N+1.
- Throughput: one write per 2 cycles and one read per 2 cycles with BREADY/RREADY held high. Reads and writes may run concurrently.
- BVALID/RVALID, once asserted, hold with stable BRESP/RDATA/RRESP until accepted.

## Configuration

- AXIL_REGBANK_SLVERR_EN defined: index ≥ NUM_REGS returns SLVERR (2'b10) on BRESP or RRESP, with RDATA=0. Writes to RO registers still return OKAY.
- Undefined: all accesses return OKAY. Out-of-range writes are dropped; out-of-range reads return 0.

## Test plan

- Reset, then write 0x1,0x2,0x3,0x4 to addrs 0x0..0xC with WSTRB=0xF, then read back → RDATA 0x1..0x4, RRESP=0, wr_pulse[0..3] each high for one cycle.
- Write 0xFFFFFFFF to reg 1, then write 0x000000AB with WSTRB=0x1 → reads 0xFFFFFFAB.
- W presented 3 cycles before AW at reg 2 (data 0x55) → single commit, BVALID one cycle after AW handshake, reg_out slice 2 = 0x55.
- RO_MASK=0x80, status_in[7]=0xCAFE0001; write 0x12 to 0x1C then read → BRESP=0, no wr_pulse[7], RDATA=0xCAFE0001.
- NUM_REGS=6 with SLVERR_EN: write/read addr 0x18 → BRESP=RRESP=2'b10, RDATA=0, no reg change. Without SLVERR_EN → OKAY, RDATA=0.
- BREADY held low 10 cycles after write, then ARESETN pulsed low → BVALID=0 and readies 0 immediately; after release, the register holds 0.

Source files
------------

// File: rtl/axil_regbank_if.sv
// AXI4-Lite bus bundle for axil_regbank: AW/W/B/AR/R channels with valid/ready handshakes.
// Clock and reset stay outside the bundle as plain ports of the bank.
interface axil_regbank_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_regbank.sv
// AXI4-Lite register bank with byte strobes, RO status mirrors, write pulses; AXIL_REGBANK_SLVERR_EN adds SLVERR out of range.
// Latency: BVALID/RVALID and reg_out/wr_pulse update one cycle after the completing AW/W or AR handshake.
// Backpressure: one write and one read in flight; readies stay low until BREADY/RREADY accept the response.
module axil_regbank #(
    parameter int                  C_S_AXI_DATA_WIDTH = 32,
    parameter int                  NUM_REGS           = 8,
    parameter int                  C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [NUM_REGS-1:0] RO_MASK            = '0
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETN,
    axil_regbank_if.slave                          s_axi,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]                    wr_pulse
);
    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int AW  = C_S_AXI_ADDR_WIDTH;
    localparam int SW  = DW / 8;
    localparam int LSB = $clog2(SW);
    localparam int IW  = AW - LSB;

`ifdef AXIL_REGBANK_SLVERR_EN
    localparam logic SLVERR_EN = 1'b1;
`else
    localparam logic SLVERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    w_state_t      w_state;
    r_state_t      r_state;
    logic          rdy_en;
    logic          aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
    logic [1:0]    b_resp, r_resp;
    logic [DW-1:0] r_dat;
    logic [IW-1:0] aw_idx_q;
    logic [DW-1:0] w_dat_q;
    logic [SW-1:0] w_strb_q;
    logic [DW-1:0] regs [NUM_REGS];

    assign s_axi.awready = aw_rdy;
    assign s_axi.wready  = w_rdy;
    assign s_axi.bvalid  = b_vld;
    assign s_axi.bresp   = b_resp;
    assign s_axi.arready = ar_rdy;
    assign s_axi.rvalid  = r_vld;
    assign s_axi.rresp   = r_resp;
    assign s_axi.rdata   = r_dat;

    logic          aw_hs, w_hs, ar_hs, wr_commit, wr_en, wr_ro;
    logic          wr_in_range, rd_in_range;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [DW-1:0] wr_dat, rd_dat;
    logic [SW-1:0] wr_strb;
    logic [1:0]    wr_resp, rd_resp;

    assign aw_hs = s_axi.awvalid & aw_rdy;
    assign w_hs  = s_axi.wvalid & w_rdy;
    assign ar_hs = s_axi.arvalid & ar_rdy;

    // Whichever half arrived first comes from the holding register.
    assign wr_idx  = (w_state == W_ADDR) ? aw_idx_q : s_axi.awaddr[AW-1:LSB];
    assign wr_dat  = (w_state == W_DATA) ? w_dat_q  : s_axi.wdata;
    assign wr_strb = (w_state == W_DATA) ? w_strb_q : s_axi.wstrb;
    assign rd_idx  = s_axi.araddr[AW-1:LSB];

    assign wr_in_range = int'(wr_idx) < NUM_REGS;
    assign rd_in_range = int'(rd_idx) < NUM_REGS;
    assign wr_resp     = (SLVERR_EN && !wr_in_range) ? 2'b10 : 2'b00;
    assign rd_resp     = (SLVERR_EN && !rd_in_range) ? 2'b10 : 2'b00;

    always_comb begin
        wr_commit = 1'b0;
        case (w_state)
            W_IDLE:  wr_commit = aw_hs & w_hs;
            W_ADDR:  wr_commit = w_hs;
            W_DATA:  wr_commit = aw_hs;
            default: wr_commit = 1'b0;
        endcase
    end

    always_comb begin
        wr_ro  = 1'b0;
        rd_dat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IW'(i))
                wr_ro = RO_MASK[i];
            if (rd_idx == IW'(i))
                rd_dat = RO_MASK[i] ? status_in[i*DW +: DW] : regs[i];
        end
    end

    assign wr_en = wr_commit & wr_in_range & ~wr_ro;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state  <= W_IDLE;
            rdy_en   <= 1'b0;
            aw_rdy   <= 1'b0;
            w_rdy    <= 1'b0;
            b_vld    <= 1'b0;
            b_resp   <= 2'b00;
            aw_idx_q <= '0;
            w_dat_q  <= '0;
            w_strb_q <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (wr_commit) begin
                w_state <= W_RESP;
                aw_rdy  <= 1'b0;
                w_rdy   <= 1'b0;
                b_vld   <= 1'b1;
                b_resp  <= wr_resp;
            end else begin
                case (w_state)
                    W_IDLE: begin
                        if (aw_hs) begin
                            w_state  <= W_ADDR;
                            aw_idx_q <= s_axi.awaddr[AW-1:LSB];
                            aw_rdy   <= 1'b0;
                        end else if (w_hs) begin
                            w_state  <= W_DATA;
                            w_dat_q  <= s_axi.wdata;
                            w_strb_q <= s_axi.wstrb;
                            w_rdy    <= 1'b0;
                        end else begin
                            // rdy_en is one edge late, so readies rise on the second edge out of reset.
                            aw_rdy <= rdy_en;
                            w_rdy  <= rdy_en;
                        end
                    end
                    W_RESP: begin
                        if (s_axi.bready) begin
                            w_state <= W_IDLE;
                            b_vld   <= 1'b0;
                            aw_rdy  <= 1'b1;
                            w_rdy   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= R_IDLE;
            ar_rdy  <= 1'b0;
            r_vld   <= 1'b0;
            r_resp  <= 2'b00;
            r_dat   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state <= R_DATA;
                        ar_rdy  <= 1'b0;
                        r_vld   <= 1'b1;
                        r_dat   <= rd_dat;
                        r_resp  <= rd_resp;
                    end else begin
                        ar_rdy <= rdy_en;
                    end
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        r_state <= R_IDLE;
                        r_vld   <= 1'b0;
                        ar_rdy  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Reads sample regs before this edge's update, so a same-edge read sees the old value.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && wr_idx == IW'(i)) begin
                    wr_pulse[i] <= 1'b1;
                    for (int b = 0; b < SW; b++)
                        if (wr_strb[b])
                            regs[i][b*8 +: 8] <= wr_dat[b*8 +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DW +: DW] = regs[g];
    end

    logic unused_bits;
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                           s_axi.awaddr[LSB-1:0], s_axi.araddr[LSB-1:0]};
endmodule

// File: tb/tb_axil_regbank.sv
// Bench for axil_regbank: two banks (8 regs with reg 7 read-only, and 6 regs) share one master; a queue scoreboard checks B and R responses.
module tb_axil_regbank;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NA = 8;
    localparam int NB = 6;
`ifdef AXIL_REGBANK_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic          bready = 1'b1, rready = 1'b1;

    logic [NA*DW-1:0] status_a, reg_out_a;
    logic [NB*DW-1:0] status_b, reg_out_b;
    logic [NA-1:0]    wr_pulse_a;
    logic [NB-1:0]    wr_pulse_b;

    axil_regbank_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    axil_regbank_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

    assign ifa.awaddr = awaddr;  assign ifb.awaddr = awaddr;
    assign ifa.awprot = 3'b000;  assign ifb.awprot = 3'b000;
    assign ifa.awvalid = awvalid; assign ifb.awvalid = awvalid;
    assign ifa.wdata = wdata;    assign ifb.wdata = wdata;
    assign ifa.wstrb = wstrb;    assign ifb.wstrb = wstrb;
    assign ifa.wvalid = wvalid;  assign ifb.wvalid = wvalid;
    assign ifa.bready = bready;  assign ifb.bready = bready;
    assign ifa.araddr = araddr;  assign ifb.araddr = araddr;
    assign ifa.arprot = 3'b000;  assign ifb.arprot = 3'b000;
    assign ifa.arvalid = arvalid; assign ifb.arvalid = arvalid;
    assign ifa.rready = rready;  assign ifb.rready = rready;

    axil_regbank #(.C_S_AXI_DATA_WIDTH(DW), .NUM_REGS(NA), .C_S_AXI_ADDR_WIDTH(AW),
                   .RO_MASK(8'h80)) dut_a (
        .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(ifa),
        .reg_out(reg_out_a), .status_in(status_a), .wr_pulse(wr_pulse_a));

    axil_regbank #(.C_S_AXI_DATA_WIDTH(DW), .NUM_REGS(NB), .C_S_AXI_ADDR_WIDTH(AW),
                   .RO_MASK(6'h00)) dut_b (
        .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(ifb),
        .reg_out(reg_out_b), .status_in(status_b), .wr_pulse(wr_pulse_b));

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] ma [NA];
    logic [DW-1:0] mb [NB];
    logic [1:0]  qa_b[$], qb_b[$];
    logic [33:0] qa_r[$], qb_r[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Response monitors: pop expected responses as each B/R beat is accepted.
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (ifa.bvalid && bready) begin
                if (qa_b.size() == 0) check("a_b_unexpected", ifa.bvalid, 0);
                else check("a_bresp", ifa.bresp, qa_b.pop_front());
            end
            if (ifb.bvalid && bready) begin
                if (qb_b.size() == 0) check("b_b_unexpected", ifb.bvalid, 0);
                else check("b_bresp", ifb.bresp, qb_b.pop_front());
            end
            if (ifa.rvalid && rready) begin
                if (qa_r.size() == 0) check("a_r_unexpected", ifa.rvalid, 0);
                else check("a_rresp_rdata", {ifa.rresp, ifa.rdata}, qa_r.pop_front());
            end
            if (ifb.rvalid && rready) begin
                if (qb_r.size() == 0) check("b_r_unexpected", ifb.rvalid, 0);
                else check("b_rresp_rdata", {ifb.rresp, ifb.rdata}, qb_r.pop_front());
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < NA; i++) ma[i] = '0;
        for (int i = 0; i < NB; i++) mb[i] = '0;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [3:0] s, input int aw_delay);
        int n;
        int idx;
        logic aw_go, w_go, aw_done, w_done;
        logic [NA-1:0] pa;
        logic [NB-1:0] pb;
        idx = int'(a[AW-1:2]);
        pa = '0;
        pb = '0;
        if (idx != 7) begin
            pa[idx] = 1'b1;
            for (int b = 0; b < 4; b++) if (s[b]) ma[idx][b*8 +: 8] = d[b*8 +: 8];
        end
        qa_b.push_back(2'b00);
        if (idx < NB) begin
            pb[idx] = 1'b1;
            for (int b = 0; b < 4; b++) if (s[b]) mb[idx][b*8 +: 8] = d[b*8 +: 8];
            qb_b.push_back(2'b00);
        end else begin
            qb_b.push_back(OOR_RESP);
        end

        @(negedge ACLK);
        awaddr = a; wdata = d; wstrb = s;
        wvalid = 1'b1;
        awvalid = (aw_delay == 0);
        n = 0; aw_done = 1'b0; w_done = 1'b0;
        while (!(aw_done && w_done) && n < 40) begin
            aw_go = awvalid && ifa.awready;
            w_go  = wvalid && ifa.wready;
            @(negedge ACLK);
            n++;
            if (aw_go) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_go)  begin wvalid = 1'b0;  w_done = 1'b1; end
            if (!aw_done && !awvalid && n >= aw_delay) awvalid = 1'b1;
        end
        check("wr_hs_in_budget", n < 40, 1);
        check("bvalid_latency", ifa.bvalid, 1);
        check("wr_pulse_a", wr_pulse_a, pa);
        check("wr_pulse_b", wr_pulse_b, pb);
        check("reg_out_a", reg_out_a[idx*DW +: DW], ma[idx]);
        if (idx < NB) check("reg_out_b", reg_out_b[idx*DW +: DW], mb[idx]);
        @(negedge ACLK);
        check("wr_pulse_a_one_cycle", wr_pulse_a, 0);
        check("bvalid_after_accept", ifa.bvalid, !bready);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int rhold);
        int n;
        int idx;
        logic go;
        logic [33:0] ea;
        idx = int'(a[AW-1:2]);
        ea = (idx == 7) ? {2'b00, status_a[7*DW +: DW]} : {2'b00, ma[idx]};
        qa_r.push_back(ea);
        if (idx < NB) qb_r.push_back({2'b00, mb[idx]});
        else qb_r.push_back({OOR_RESP, 32'h0});

        @(negedge ACLK);
        araddr = a; arvalid = 1'b1; rready = (rhold == 0);
        n = 0;
        while (arvalid && n < 20) begin
            go = ifa.arready;
            @(negedge ACLK);
            n++;
            if (go) arvalid = 1'b0;
        end
        check("rd_hs_in_budget", n < 20, 1);
        check("rvalid_latency", ifa.rvalid, 1);
        for (int i = 0; i < rhold; i++) begin
            @(negedge ACLK);
            check("rvalid_hold", ifa.rvalid, 1);
            check("rdata_hold", {ifa.rresp, ifa.rdata}, ea);
        end
        if (rhold > 0) begin
            @(posedge ACLK); #1 rready = 1'b1;
            @(negedge ACLK);
        end
        @(negedge ACLK);
        check("rvalid_after_accept", ifa.rvalid, 0);
    endtask

    task automatic reset_state_checks(input string tag);
        check({tag, "_bvalid"}, ifa.bvalid, 0);
        check({tag, "_rvalid"}, ifa.rvalid, 0);
        check({tag, "_readies"}, {ifa.awready, ifa.wready, ifa.arready}, 3'b000);
        check({tag, "_resp"}, {ifa.bresp, ifa.rresp}, 4'b0000);
        check({tag, "_rdata"}, ifa.rdata, 0);
        check({tag, "_wr_pulse"}, wr_pulse_a, 0);
        check({tag, "_reg_out_zero"}, |reg_out_a, 0);
    endtask

    task automatic release_reset();
        @(negedge ACLK);
        ARESETN = 1'b1;
        bready = 1'b1;
        rready = 1'b1;
        @(posedge ACLK); #1;
        check("rdy_low_after_edge1", {ifa.awready, ifa.wready, ifa.arready}, 3'b000);
        @(posedge ACLK); #1;
        check("rdy_high_after_edge2", {ifa.awready, ifa.wready, ifa.arready}, 3'b111);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, elapsed %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [2:0] ri;
        for (int i = 0; i < NA; i++) status_a[i*DW +: DW] = $urandom;
        for (int i = 0; i < NB; i++) status_b[i*DW +: DW] = $urandom;
        status_a[7*DW +: DW] = 32'hCAFE0001;
        model_clear();

        repeat (3) @(negedge ACLK);
        reset_state_checks("rst");
        release_reset();

        for (int i = 0; i < 4; i++)
            axi_write(AW'(i * 4), DW'(i + 1), 4'hF, 0);
        for (int i = 0; i < 4; i++)
            axi_read(AW'(i * 4), 0);

        axi_write(5'h04, 32'hFFFFFFFF, 4'hF, 0);
        axi_write(5'h04, 32'h000000AB, 4'h1, 0);
        axi_read(5'h04, 0);

        axi_write(5'h08, 32'h00000055, 4'hF, 3);
        check("w_first_reg2", reg_out_a[2*DW +: DW], 32'h00000055);

        axi_write(5'h1C, 32'h00000012, 4'hF, 0);
        axi_read(5'h1C, 3);

        axi_write(5'h18, 32'h0000DEAD, 4'hF, 0);
        axi_read(5'h18, 0);

        for (int k = 0; k < 10; k++) begin
            ri = 3'($urandom_range(0, 7));
            axi_write({ri, 2'b00}, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
            ri = 3'($urandom_range(0, 7));
            axi_read({ri, 2'b00}, $urandom_range(0, 1));
        end

        @(posedge ACLK); #1 bready = 1'b0;
        axi_write(5'h0C, 32'h00000077, 4'hF, 0);
        repeat (10) @(negedge ACLK);
        check("b_held_vld", ifa.bvalid, 1);
        check("b_held_resp", ifa.bresp, 2'b00);
        #2 ARESETN = 1'b0;
        #1;
        reset_state_checks("midrst");
        qa_b.delete();
        qb_b.delete();
        model_clear();
        release_reset();
        check("reg3_after_reset", reg_out_a[3*DW +: DW], 0);
        axi_read(5'h0C, 0);

        repeat (2) @(negedge ACLK);
        check("sb_a_b_drained", qa_b.size(), 0);
        check("sb_b_b_drained", qb_b.size(), 0);
        check("sb_a_r_drained", qa_r.size(), 0);
        check("sb_b_r_drained", qb_r.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
